// File: rtl/mvb_rx_decoder.sv
// MVB receive decoder: oversampled Manchester line -> start delimiter detect, MSB-first 16-bit words, end/error flags.
// Optional build macro MVB_RX_GLITCH_FILTER_EN inserts a 3-sample majority filter ahead of edge detection.
module mvb_rx_decoder #(
    parameter int          SAMPLES_PER_HALF = 8,
    parameter logic [17:0] MASTER_DELIM     = 18'b10_11_00_01_11_00_01_01_01,
    parameter logic [17:0] SLAVE_DELIM      = 18'b10_10_10_10_00_11_10_00_11,
    parameter int          MAX_WORDS        = 64,
    parameter int          IDLE_TIMEOUT     = 48
) (
    input  logic        clk_24M,
    input  logic        rst,
    input  logic        line_in,
    output logic [15:0] rx_data,
    output logic        rx_data_valid,
    output logic        master_frame,
    output logic        slave_frame,
    output logic [6:0]  frame_length,
    output logic        decode_frame_over,
    output logic        code_error,
    output logic        busy
);
    localparam int PW = $clog2(SAMPLES_PER_HALF);
    localparam int TW = $clog2(IDLE_TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, SYNC, DATA} state_t;

    logic [1:0]    sync_q;
    logic [2:0]    hist_q;
    logic          cur, prev, edge_det;
    logic [PW-1:0] phase_q, phase_d;
    logic [TW-1:0] idle_q, idle_d;
    logic          cap_stb, timeout;
    logic [1:0]    vld_pipe_q, bit_pipe_q;
    logic          cap, cbit;
    logic [17:0]   shreg_q, shreg_d;

    state_t        state_q, state_d;
    logic          master_q, master_d, slave_q, slave_d, busy_q, busy_d;
    logic [6:0]    flen_q, flen_d;
    logic [15:0]   rx_data_q, rx_data_d, word_q, word_d;
    logic          rx_valid_q, rx_valid_d, over_q, over_d, err_q, err_d;
    logic [3:0]    bit_cnt_q, bit_cnt_d;
    logic          pair_ph_q, pair_ph_d;
    logic          fail, done;

`ifdef MVB_RX_GLITCH_FILTER_EN
    logic filt_q, filt_prev_q;
    always_ff @(posedge clk_24M) begin
        if (rst) begin
            filt_q      <= 1'b0;
            filt_prev_q <= 1'b0;
        end else begin
            filt_q      <= (hist_q[0] & hist_q[1]) | (hist_q[0] & hist_q[2]) | (hist_q[1] & hist_q[2]);
            filt_prev_q <= filt_q;
        end
    end
    assign cur  = filt_q;
    assign prev = filt_prev_q;
`else
    assign cur  = hist_q[1];
    assign prev = hist_q[2];
`endif

    assign edge_det = cur ^ prev;
    assign cap_stb  = (phase_q == PW'(SAMPLES_PER_HALF / 2));
    assign timeout  = (idle_q == TW'(IDLE_TIMEOUT));
    assign cap      = vld_pipe_q[1];
    assign cbit     = bit_pipe_q[1];

    always_comb begin
        phase_d = phase_q + 1'b1;
        if (edge_det || phase_q == PW'(SAMPLES_PER_HALF - 1))
            phase_d = '0;
        idle_d = idle_q;
        if (edge_det)
            idle_d = '0;
        else if (!timeout)
            idle_d = idle_q + 1'b1;
        shreg_d = cap ? {shreg_q[16:0], cbit} : shreg_q;
    end

    always_comb begin
        state_d    = state_q;
        master_d   = master_q;
        slave_d    = slave_q;
        flen_d     = flen_q;
        rx_data_d  = rx_data_q;
        word_d     = word_q;
        bit_cnt_d  = bit_cnt_q;
        pair_ph_d  = pair_ph_q;
        rx_valid_d = 1'b0;
        over_d     = 1'b0;
        err_d      = 1'b0;
        fail       = 1'b0;
        done       = 1'b0;
        case (state_q)
            IDLE: if (edge_det) state_d = SYNC;
            SYNC: begin
                if (cap && (shreg_d == MASTER_DELIM || shreg_d == SLAVE_DELIM)) begin
                    state_d   = DATA;
                    master_d  = (shreg_d == MASTER_DELIM);
                    slave_d   = (shreg_d == SLAVE_DELIM);
                    flen_d    = '0;
                    bit_cnt_d = '0;
                    pair_ph_d = 1'b0;
                end else if (timeout) begin
                    state_d = IDLE;
                end
            end
            DATA: begin
                if (timeout) begin
                    fail = 1'b1;
                end else if (cap) begin
                    pair_ph_d = ~pair_ph_q;
                    // shreg_q[0] is the first half of the pair; it equals the data bit for 10/01
                    if (pair_ph_q) begin
                        case ({shreg_q[0], cbit})
                            2'b10, 2'b01: begin
                                word_d    = {word_q[14:0], shreg_q[0]};
                                bit_cnt_d = bit_cnt_q + 1'b1;
                                if (bit_cnt_q == 4'd15) begin
                                    if (flen_q == 7'(MAX_WORDS)) begin
                                        fail = 1'b1;
                                    end else begin
                                        rx_data_d  = word_d;
                                        rx_valid_d = 1'b1;
                                        flen_d     = flen_q + 1'b1;
                                    end
                                end
                            end
                            2'b00: begin
                                if (bit_cnt_q == 4'd0 && flen_q != 7'd0)
                                    done = 1'b1;
                                else
                                    fail = 1'b1;
                            end
                            default: fail = 1'b1;
                        endcase
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (fail || done) begin
            state_d  = IDLE;
            master_d = 1'b0;
            slave_d  = 1'b0;
            err_d    = fail;
            over_d   = done;
        end
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk_24M) begin
        if (rst) begin
            sync_q     <= '0;
            hist_q     <= '0;
            phase_q    <= '0;
            idle_q     <= '0;
            vld_pipe_q <= '0;
            bit_pipe_q <= '0;
            shreg_q    <= '0;
            state_q    <= IDLE;
            master_q   <= 1'b0;
            slave_q    <= 1'b0;
            busy_q     <= 1'b0;
            flen_q     <= '0;
            rx_data_q  <= '0;
            word_q     <= '0;
            rx_valid_q <= 1'b0;
            over_q     <= 1'b0;
            err_q      <= 1'b0;
            bit_cnt_q  <= '0;
            pair_ph_q  <= 1'b0;
        end else begin
            sync_q     <= {sync_q[0], line_in};
            hist_q     <= {hist_q[1:0], sync_q[1]};
            phase_q    <= phase_d;
            idle_q     <= idle_d;
            // prev is the pre-edge sample, so a capture coinciding with an edge stays in its half-bit
            vld_pipe_q <= {vld_pipe_q[0], cap_stb};
            bit_pipe_q <= {bit_pipe_q[0], prev};
            shreg_q    <= shreg_d;
            state_q    <= state_d;
            master_q   <= master_d;
            slave_q    <= slave_d;
            busy_q     <= busy_d;
            flen_q     <= flen_d;
            rx_data_q  <= rx_data_d;
            word_q     <= word_d;
            rx_valid_q <= rx_valid_d;
            over_q     <= over_d;
            err_q      <= err_d;
            bit_cnt_q  <= bit_cnt_d;
            pair_ph_q  <= pair_ph_d;
        end
    end

    assign rx_data           = rx_data_q;
    assign rx_data_valid     = rx_valid_q;
    assign master_frame      = master_q;
    assign slave_frame       = slave_q;
    assign frame_length      = flen_q;
    assign decode_frame_over = over_q;
    assign code_error        = err_q;
    assign busy              = busy_q;
endmodule

// File: tb/tb_mvb_rx_decoder.sv
// Directed bench for mvb_rx_decoder: drives Manchester frames at 8 samples per half-bit and checks decoded results.
`timescale 1ns/1ps
module tb_mvb_rx_decoder;
    logic        clk_24M = 1'b0;
    logic        rst = 1'b1;
    logic        line_in = 1'b0;
    logic [15:0] rx_data;
    logic        rx_data_valid, master_frame, slave_frame, decode_frame_over, code_error, busy;
    logic [6:0]  frame_length;

    localparam logic [17:0] MDEL = 18'b10_11_00_01_11_00_01_01_01;
    localparam logic [17:0] SDEL = 18'b10_10_10_10_00_11_10_00_11;

    int n_cmp = 0, n_mis = 0;
    int n_vld = 0, n_over = 0, n_err = 0, n_vm = 0, n_vs = 0, n_flag = 0;
    int b_vld, b_over, b_err, b_vm, b_vs, b_flag, b_q;
    logic [15:0] got[$];
    logic [15:0] jw[8];

    mvb_rx_decoder dut (
        .clk_24M(clk_24M), .rst(rst), .line_in(line_in),
        .rx_data(rx_data), .rx_data_valid(rx_data_valid),
        .master_frame(master_frame), .slave_frame(slave_frame),
        .frame_length(frame_length), .decode_frame_over(decode_frame_over),
        .code_error(code_error), .busy(busy)
    );

    always #21 clk_24M = ~clk_24M;

    always @(negedge clk_24M) begin
        if (rx_data_valid) begin
            n_vld++;
            got.push_back(rx_data);
            if (master_frame) n_vm++;
            if (slave_frame) n_vs++;
        end
        if (decode_frame_over) begin
            n_over++;
            if (master_frame || slave_frame || busy) n_flag++;
        end
        if (code_error) begin
            n_err++;
            if (master_frame || slave_frame || busy) n_flag++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic mark();
        b_vld = n_vld; b_over = n_over; b_err = n_err;
        b_vm = n_vm; b_vs = n_vs; b_flag = n_flag; b_q = got.size();
    endtask

    function automatic logic [15:0] got_at(input int i);
        if (i < got.size()) return got[i];
        return 16'hxxxx;
    endfunction

    task automatic half(input logic v, input int n);
        line_in = v;
        repeat (n) @(negedge clk_24M);
    endtask

    task automatic send_delim(input logic [17:0] d);
        for (int i = 17; i >= 0; i--) half(d[i], 8);
    endtask

    task automatic send_bit(input logic b, input int h2);
        half(b, 8);
        half(~b, h2);
    endtask

    task automatic send_word(input logic [15:0] w);
        for (int i = 15; i >= 0; i--) send_bit(w[i], 8);
    endtask

    task automatic chk_zero_outs(input string tag);
        chk({tag, "_rx_data"}, rx_data, 16'h0);
        chk({tag, "_valid"}, rx_data_valid, 1'b0);
        chk({tag, "_master"}, master_frame, 1'b0);
        chk({tag, "_slave"}, slave_frame, 1'b0);
        chk({tag, "_flen"}, frame_length, 7'd0);
        chk({tag, "_over"}, decode_frame_over, 1'b0);
        chk({tag, "_err"}, code_error, 1'b0);
        chk({tag, "_busy"}, busy, 1'b0);
    endtask

    initial begin
        jw = '{16'h1357, 16'h8000, 16'h0F0F, 16'hDEAD, 16'h0000, 16'hBEEF, 16'h7FFE, 16'h2468};
        repeat (4) @(negedge clk_24M);
        chk_zero_outs("reset");
        rst = 1'b0;
        half(1'b0, 80);

        // master frame, two words, clean end
        mark();
        send_delim(MDEL);
        send_word(16'hA5C3);
        send_word(16'h0001);
        half(1'b0, 100);
        chk("m2_nvld", n_vld - b_vld, 2);
        chk("m2_w0", got_at(b_q), 16'hA5C3);
        chk("m2_w1", got_at(b_q + 1), 16'h0001);
        chk("m2_flen", frame_length, 7'd2);
        chk("m2_over", n_over - b_over, 1);
        chk("m2_err", n_err - b_err, 0);
        chk("m2_master_at_vld", n_vm - b_vm, 2);
        chk("m2_flags_at_end", n_flag - b_flag, 0);
        chk("m2_busy_after", busy, 1'b0);

        // slave frame, one word
        mark();
        send_delim(SDEL);
        send_word(16'hFFFF);
        half(1'b0, 100);
        chk("s1_nvld", n_vld - b_vld, 1);
        chk("s1_slave_at_vld", n_vs - b_vs, 1);
        chk("s1_rx_data", rx_data, 16'hFFFF);
        chk("s1_flen", frame_length, 7'd1);
        chk("s1_over", n_over - b_over, 1);
        chk("s1_err", n_err - b_err, 0);

        // NL after 9 bits is a violation
        mark();
        send_delim(MDEL);
        for (int i = 0; i < 9; i++) send_bit(i[0], 8);
        half(1'b0, 100);
        chk("nl9_err", n_err - b_err, 1);
        chk("nl9_over", n_over - b_over, 0);
        chk("nl9_flen", frame_length, 7'd0);
        chk("nl9_nvld", n_vld - b_vld, 0);
        chk("nl9_flags_at_err", n_flag - b_flag, 0);

        // 65 words overflow the frame
        mark();
        send_delim(MDEL);
        for (int i = 0; i < 65; i++) send_word(16'h5A00 | 16'(i));
        half(1'b0, 100);
        chk("ovf_nvld", n_vld - b_vld, 64);
        chk("ovf_first", got_at(b_q), 16'h5A00);
        chk("ovf_last", got_at(b_q + 63), 16'h5A3F);
        chk("ovf_err", n_err - b_err, 1);
        chk("ovf_over", n_over - b_over, 0);
        chk("ovf_flen", frame_length, 7'd64);

        // jittered bit period, then line stuck high mid-word
        mark();
        send_delim(MDEL);
        for (int k = 0; k < 8; k++)
            for (int i = 15; i >= 0; i--) send_bit(jw[k][i], 7 + ((k * 16 + i) % 3));
        for (int i = 0; i < 5; i++) send_bit(i[0], 8);
        half(1'b1, 60);
        half(1'b0, 100);
        chk("jit_nvld", n_vld - b_vld, 8);
        for (int k = 0; k < 8; k++) chk($sformatf("jit_w%0d", k), got_at(b_q + k), jw[k]);
        chk("jit_err", n_err - b_err, 1);
        chk("jit_over", n_over - b_over, 0);
        chk("jit_flen", frame_length, 7'd8);

        // synchronous reset mid-word, then a clean frame
        mark();
        send_delim(MDEL);
        for (int i = 0; i < 7; i++) send_bit(1'b1, 8);
        rst = 1'b1;
        @(negedge clk_24M);
        chk_zero_outs("midrst");
        rst = 1'b0;
        half(1'b0, 100);
        chk("midrst_no_pulse", (n_err - b_err) + (n_over - b_over) + (n_vld - b_vld), 0);
        mark();
        send_delim(MDEL);
        send_word(16'h1234);
        half(1'b0, 100);
        chk("post_nvld", n_vld - b_vld, 1);
        chk("post_word", got_at(b_q), 16'h1234);
        chk("post_flen", frame_length, 7'd1);
        chk("post_over", n_over - b_over, 1);
        chk("post_err", n_err - b_err, 0);

`ifdef MVB_RX_GLITCH_FILTER_EN
        // a single-sample glitch inside a half-bit is absorbed
        mark();
        send_delim(MDEL);
        for (int i = 15; i >= 0; i--) begin
            if (i == 9) begin
                half(1'b0, 3); half(1'b1, 1); half(1'b0, 4); half(1'b1, 8);
            end else begin
                send_bit(((16'h00FF >> i) & 16'h1) != 0, 8);
            end
        end
        half(1'b0, 100);
        chk("glitch_nvld", n_vld - b_vld, 1);
        chk("glitch_word", got_at(b_q), 16'h00FF);
        chk("glitch_err", n_err - b_err, 0);
        chk("glitch_over", n_over - b_over, 1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
